// File: rtl/uart_rx_ctrl.sv
// Purpose : sequences the UART receiver; holds its config; screens frames; buffers good bytes; counts errors.
// Latency : config applies 1 cycle after write (or after rx goes idle); byte visible on out_* 1 cycle after rx_data_valid.
// Backpres: out_valid/out_ready handshake; a good byte arriving into a full FIFO without a pop is dropped and sets overflow.
//
// Ports:
//   CLK, RST                      clock, async active-low reset
//   cfg_wr/cfg_prescale/cfg_par_* config write request (prescale must be 8, 16 or 32)
//   Prescale/PAR_EN/PAR_TYP       applied config to receiver
//   cfg_pending, cfg_err          write waiting for idle receiver / illegal-write pulse
//   rx_busy, rx_data*, rx_*_err   receiver status and completed frame
//   out_data/out_valid/out_ready  byte stream (show-ahead FIFO head)
//   fifo_count, overflow          FIFO occupancy, sticky drop flag
//   par_err_cnt, stp_err_cnt      saturating error counters; err_clr clears them and overflow
//   rx_idle_to                    idle timeout flag, only with UART_RX_CTRL_IDLE_TIMEOUT_EN defined
//
// Optional feature macro: UART_RX_CTRL_IDLE_TIMEOUT_EN

module uart_rx_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8,
  parameter int PRESCALE_RST = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_wr,
  input  logic [5:0]       cfg_prescale,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  output logic [5:0]       Prescale,
  output logic             PAR_EN,
  output logic             PAR_TYP,
  output logic             cfg_pending,
  output logic             cfg_err,
  input  logic             rx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  input  logic             rx_par_err,
  input  logic             rx_stp_err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       fifo_count,
  output logic             overflow,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] stp_err_cnt,
  input  logic             err_clr,
  output logic             rx_idle_to
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------------------
  // Config FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {CFG_IDLE = 1'b0, CFG_WAIT = 1'b1} cfg_state_t;

  cfg_state_t r_state;
  cfg_state_t w_state_nxt;

  logic       w_legal;
  logic       w_wr_ok;
  logic       w_rx_free;
  logic       w_apply;
  logic       w_apply_new;
  logic       w_shadow_ld;

  logic [5:0] r_prescale;
  logic       r_par_en;
  logic       r_par_typ;
  logic [5:0] r_sh_prescale;
  logic       r_sh_par_en;
  logic       r_sh_par_typ;
  logic       r_cfg_err;

  assign w_legal   = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
  assign w_wr_ok   = cfg_wr & w_legal;
  // A completing frame counts as busy so config never changes under it.
  assign w_rx_free = ~rx_busy & ~rx_data_valid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= CFG_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CFG_IDLE: if (w_wr_ok && !w_rx_free) w_state_nxt = CFG_WAIT;
      CFG_WAIT: if (w_rx_free)             w_state_nxt = CFG_IDLE;
      default:                             w_state_nxt = CFG_IDLE;
    endcase
  end

  always_comb begin
    w_apply     = 1'b0;
    w_apply_new = 1'b0;
    w_shadow_ld = 1'b0;
    case (r_state)
      CFG_IDLE: begin
        if (w_wr_ok) begin
          if (w_rx_free) begin
            w_apply     = 1'b1;
            w_apply_new = 1'b1;
          end else begin
            w_shadow_ld = 1'b1;
          end
        end
      end
      CFG_WAIT: begin
        if (w_rx_free) begin
          // A write landing in the release cycle supersedes the shadow.
          w_apply     = 1'b1;
          w_apply_new = w_wr_ok;
        end else if (w_wr_ok) begin
          w_shadow_ld = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prescale    <= 6'(PRESCALE_RST);
      r_par_en      <= 1'b1;
      r_par_typ     <= 1'b0;
      r_sh_prescale <= 6'(PRESCALE_RST);
      r_sh_par_en   <= 1'b1;
      r_sh_par_typ  <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= cfg_wr & ~w_legal;
      if (w_shadow_ld) begin
        r_sh_prescale <= cfg_prescale;
        r_sh_par_en   <= cfg_par_en;
        r_sh_par_typ  <= cfg_par_typ;
      end
      if (w_apply) begin
        r_prescale <= w_apply_new ? cfg_prescale : r_sh_prescale;
        r_par_en   <= w_apply_new ? cfg_par_en   : r_sh_par_en;
        r_par_typ  <= w_apply_new ? cfg_par_typ  : r_sh_par_typ;
      end
    end
  end

  assign Prescale    = r_prescale;
  assign PAR_EN      = r_par_en;
  assign PAR_TYP     = r_par_typ;
  assign cfg_pending = (r_state == CFG_WAIT);
  assign cfg_err     = r_cfg_err;

  // ---------------------------------------------------------------------------
  // Frame screening and error counters
  // ---------------------------------------------------------------------------
  logic             w_par_inc;
  logic             w_stp_inc;
  logic             w_push;
  logic [CNT_W-1:0] r_par_cnt;
  logic [CNT_W-1:0] r_stp_cnt;

  assign w_par_inc = rx_data_valid & rx_par_err;
  assign w_stp_inc = rx_data_valid & rx_stp_err;
  assign w_push    = rx_data_valid & ~rx_par_err & ~rx_stp_err;

  // On err_clr a same-cycle event leaves the counter at 1 rather than 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_cnt <= '0;
      r_stp_cnt <= '0;
    end else begin
      if (err_clr)                         r_par_cnt <= CNT_W'(w_par_inc);
      else if (w_par_inc && ~&r_par_cnt)   r_par_cnt <= r_par_cnt + 1'b1;
      if (err_clr)                         r_stp_cnt <= CNT_W'(w_stp_inc);
      else if (w_stp_inc && ~&r_stp_cnt)   r_stp_cnt <= r_stp_cnt + 1'b1;
    end
  end

  assign par_err_cnt = r_par_cnt;
  assign stp_err_cnt = r_stp_cnt;

  // ---------------------------------------------------------------------------
  // Byte FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_pop;
  logic          w_push_acc;
  logic          w_ovf_set;

  assign out_valid  = (r_count != '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_acc = w_push & (~w_full | w_pop);
  assign w_ovf_set  = w_push & w_full & ~w_pop;

  always_ff @(posedge CLK) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (err_clr) r_overflow <= w_ovf_set;
      else         r_overflow <= r_overflow | w_ovf_set;
    end
  end

  assign out_data   = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_count = 5'(r_count);
  assign overflow   = r_overflow;

  // ---------------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------------
`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
  logic [9:0] r_to_cnt;
  logic       r_idle_to;
  logic       w_to_load;
  logic       w_to_run;

  assign w_to_load = w_push_acc | w_pop;
  assign w_to_run  = out_valid & ~rx_busy;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_to_cnt  <= '0;
      r_idle_to <= 1'b0;
    end else if (w_to_load) begin
      r_to_cnt  <= 10'(r_prescale) * 10'd10;
      r_idle_to <= 1'b0;
    end else if (w_to_run && (r_to_cnt != '0)) begin
      r_to_cnt <= r_to_cnt - 1'b1;
      if (r_to_cnt == 10'd1) r_idle_to <= 1'b1;
    end
  end

  assign rx_idle_to = r_idle_to;
`else
  assign rx_idle_to = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cfg_wr;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       cfg_pending;
  logic       cfg_err;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_par_err;
  logic       rx_stp_err;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] par_err_cnt;
  logic [7:0] stp_err_cnt;
  logic       err_clr;
  logic       rx_idle_to;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .CNT_W(8), .PRESCALE_RST(8)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .rx_busy(rx_busy), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow),
    .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt),
    .err_clr(err_clr), .rx_idle_to(rx_idle_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Drive for one cycle starting at a negedge; returns at the next negedge.
  task automatic cfg(input logic [5:0] p, input logic en, input logic typ);
    cfg_wr = 1'b1; cfg_prescale = p; cfg_par_en = en; cfg_par_typ = typ;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic pe, input logic se);
    rx_data = d; rx_par_err = pe; rx_stp_err = se; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
  endtask

  task automatic drain(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(first + 8'(i)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    RST = 1'b0; cfg_wr = 1'b0; cfg_prescale = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    rx_busy = 1'b0; rx_data = '0; rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_prescale", 32'(Prescale), 32'd8);
    chk("rst_par_en", 32'(PAR_EN), 32'd1);
    chk("rst_par_typ", 32'(PAR_TYP), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_par_cnt", 32'(par_err_cnt), 32'd0);
    chk("rst_stp_cnt", 32'(stp_err_cnt), 32'd0);
    chk("rst_idle_to", 32'(rx_idle_to), 32'd0);
    RST = 1'b1;
    tick();

    // Deferred write while receiver busy
    rx_busy = 1'b1;
    cfg(6'd16, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("busy_prescale", 32'(Prescale), 32'd8);
      chk("busy_pending", 32'(cfg_pending), 32'd1);
      tick();
    end
    rx_busy = 1'b0;
    tick();
    chk("rel_prescale", 32'(Prescale), 32'd16);
    chk("rel_par_en", 32'(PAR_EN), 32'd0);
    chk("rel_par_typ", 32'(PAR_TYP), 32'd1);
    chk("rel_pending", 32'(cfg_pending), 32'd0);

    // Illegal prescale
    cfg(6'd12, 1'b1, 1'b0);
    chk("ill_cfg_err", 32'(cfg_err), 32'd1);
    chk("ill_prescale", 32'(Prescale), 32'd16);
    chk("ill_par_en", 32'(PAR_EN), 32'd0);
    chk("ill_pending", 32'(cfg_pending), 32'd0);
    tick();
    chk("ill_err_pulse", 32'(cfg_err), 32'd0);

    // Immediate apply when idle
    cfg(6'd32, 1'b1, 1'b0);
    chk("imm_prescale", 32'(Prescale), 32'd32);
    chk("imm_par_en", 32'(PAR_EN), 32'd1);
    chk("imm_pending", 32'(cfg_pending), 32'd0);

    // Write in the release cycle wins over the shadow
    rx_busy = 1'b1;
    cfg(6'd16, 1'b0, 1'b1);
    chk("wait_prescale", 32'(Prescale), 32'd32);
    rx_busy = 1'b0;
    cfg(6'd8, 1'b1, 1'b0);
    chk("relwr_prescale", 32'(Prescale), 32'd8);
    chk("relwr_par_en", 32'(PAR_EN), 32'd1);
    chk("relwr_par_typ", 32'(PAR_TYP), 32'd0);
    chk("relwr_pending", 32'(cfg_pending), 32'd0);

    // Last write wins while waiting
    rx_busy = 1'b1;
    cfg(6'd16, 1'b0, 1'b0);
    cfg(6'd32, 1'b1, 1'b1);
    chk("lww_pending", 32'(cfg_pending), 32'd1);
    chk("lww_hold", 32'(Prescale), 32'd8);
    rx_busy = 1'b0;
    tick();
    chk("lww_prescale", 32'(Prescale), 32'd32);
    chk("lww_par_typ", 32'(PAR_TYP), 32'd1);
    chk("lww_pending0", 32'(cfg_pending), 32'd0);

    // Frame screening
    out_ready = 1'b1;
    frame(8'hA5, 1'b0, 1'b0);
    chk("good_valid", 32'(out_valid), 32'd1);
    chk("good_data", 32'(out_data), 32'hA5);
    frame(8'h3C, 1'b1, 1'b0);
    chk("par_drop", 32'(out_valid), 32'd0);
    chk("par_cnt1", 32'(par_err_cnt), 32'd1);
    frame(8'h0F, 1'b0, 1'b1);
    chk("stp_drop", 32'(out_valid), 32'd0);
    chk("stp_cnt1", 32'(stp_err_cnt), 32'd1);
    chk("par_cnt_keep", 32'(par_err_cnt), 32'd1);
    frame(8'h77, 1'b1, 1'b1);
    chk("both_par", 32'(par_err_cnt), 32'd2);
    chk("both_stp", 32'(stp_err_cnt), 32'd2);
    chk("both_count", 32'(fifo_count), 32'd0);

    // err_clr loses to a same-cycle error
    err_clr = 1'b1;
    frame(8'h55, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("clr_prio_par", 32'(par_err_cnt), 32'd1);
    chk("clr_stp", 32'(stp_err_cnt), 32'd0);

    // Saturation
    for (int i = 0; i < 300; i++) frame(8'h00, 1'b1, 1'b0);
    chk("par_sat", 32'(par_err_cnt), 32'd255);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("par_clr", 32'(par_err_cnt), 32'd0);
    out_ready = 1'b0;

    // Overflow
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain(8'h01, 4);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full + push + pop in the same cycle
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("full_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    frame(8'h14, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd4);
    chk("pp_overflow", 32'(overflow), 32'd0);
    drain(8'h11, 4);

    // Overflow set beats err_clr
    for (int i = 0; i < 4; i++) frame(8'h20 + 8'(i), 1'b0, 1'b0);
    err_clr = 1'b1;
    frame(8'h24, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("ovf_prio", 32'(overflow), 32'd1);
    drain(8'h20, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
